// File: rtl/axi_weight_loader_if.sv
// AXI4-Lite bus between the weight loader (master) and the synaptic-weight memory (slave).
interface axi_weight_loader_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_weight_loader.sv
// Weight loader: turns single-word weight commands into AXI4-Lite transactions,
// one outstanding transaction at a time, one response per command.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a command (cmd_ready high)
// S_WR_REQ  | AW and W channels offered, each dropped after its own handshake
// S_WR_RESP | waiting for the write response (bready high)
// S_RD_REQ  | AR channel offered until accepted
// S_RD_DATA | waiting for read data (rready high)
// S_RSP     | response held on the rsp port until consumed
module axi_weight_loader #(
  parameter int unsigned NUM_SYNAPSES = 220,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned IDX_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [IDX_W-1:0]  i_cmd_index,
  input  logic [15:0]       i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [15:0]       o_rsp_rdata,
  output logic              o_rsp_error,
  axi_weight_loader_if.master m_axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [31:0] r_awaddr;
  logic        r_awvalid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wvalid;
  logic        r_bready;
  logic [31:0] r_araddr;
  logic        r_arvalid;
  logic        r_rready;

  logic [IDX_W+1:0] w_idx_bytes;
  logic [31:0]      w_cmd_addr;
  logic             w_out_of_range;
  logic             w_cmd_fire;
  logic             w_aw_done;
  logic             w_w_done;
  logic             w_unused_rdata_hi;

  // Byte address of the requested synapse; the sum wraps modulo 2^32.
  assign w_idx_bytes    = {i_cmd_index, 2'b00};
  assign w_cmd_addr     = BASE_ADDR + 32'(w_idx_bytes);
  assign w_out_of_range = (32'(i_cmd_index) >= NUM_SYNAPSES);
  assign w_cmd_fire     = i_cmd_valid && r_cmd_ready;

  // A channel counts as done once its valid is already low or it handshakes this cycle.
  assign w_aw_done = !r_awvalid || m_axi.awready;
  assign w_w_done  = !r_wvalid  || m_axi.wready;

  // Weights are 16 bits wide; the upper half of the read word carries nothing.
  assign w_unused_rdata_hi = ^m_axi.rdata[31:16];

  // Command/transaction sequencer with every output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0;
      r_rsp_error <= 1'b0;
      r_awaddr    <= 32'h0;
      r_awvalid   <= 1'b0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= 32'h0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cmd_ready <= 1'b0;
            if (w_out_of_range) begin
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= 16'h0;
              r_state     <= S_RSP;
            end else if (i_cmd_write) begin
              r_awaddr  <= w_cmd_addr;
              r_wdata   <= {16'h0, i_cmd_wdata};
              r_wstrb   <= 4'b0011;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_araddr  <= w_cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (r_awvalid && m_axi.awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && m_axi.wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (r_bready && m_axi.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_error <= (m_axi.bresp != 2'b00);
            r_rsp_rdata <= 16'h0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (r_arvalid && m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_rready && m_axi.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= m_axi.rdata[15:0];
            r_rsp_error <= (m_axi.rresp != 2'b00);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // cmd_ready sits high in reset so it appears the moment rst drops; gate it low while rst is held.
  assign o_cmd_ready = r_cmd_ready && !rst;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_error = r_rsp_error;

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

endmodule

// File: tb/tb_axi_weight_loader.sv
// Bench for axi_weight_loader: behavioural AXI4-Lite slave with programmable
// ready/response delays, plus a weight-array reference model of expected responses.
module tb_axi_weight_loader;
  localparam int unsigned NSYN = 220;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [15:0] i_cmd_index;
  logic [15:0] i_cmd_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [15:0] o_rsp_rdata;
  logic        o_rsp_error;

  axi_weight_loader_if axi ();

  axi_weight_loader #(
    .NUM_SYNAPSES(NSYN),
    .BASE_ADDR   (BASE),
    .IDX_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_index(i_cmd_index),
    .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_error(o_rsp_error),
    .m_axi      (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Slave memory (environment) and the reference weight array (prediction).
  logic [31:0] slv_mem [0:NSYN-1];
  logic [15:0] ref_w   [0:NSYN-1];

  int          cfg_aw_delay, cfg_w_delay, cfg_b_delay, cfg_ar_delay, cfg_r_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;

  int          aw_caps, w_caps, ar_caps, valid_cycles;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit          aw_pend, aw_fire, w_pend, w_fire, ar_pend, ar_fire;
  bit          got_aw, got_w, b_pend, r_pend, b_fire, r_fire;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
  int unsigned s_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model and protocol monitor, evaluated mid-cycle.
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
    aw_caps = 0; w_caps = 0; ar_caps = 0; valid_cycles = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.arready = 0; axi.rvalid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_pend = 0; aw_fire = 0; w_pend = 0; w_fire = 0; ar_pend = 0; ar_fire = 0;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      if (axi.awvalid || axi.wvalid || axi.arvalid) valid_cycles++;
      if (aw_pend) begin
        chk("awvalid_held", 32'(axi.awvalid), 1);
        chk("awaddr_stable", axi.awaddr, prev_awaddr);
      end
      if (aw_fire) chk("awvalid_drop", 32'(axi.awvalid), 0);
      if (w_pend) begin
        chk("wvalid_held", 32'(axi.wvalid), 1);
        chk("wdata_stable", axi.wdata, prev_wdata);
      end
      if (w_fire) chk("wvalid_drop", 32'(axi.wvalid), 0);
      if (ar_pend) begin
        chk("arvalid_held", 32'(axi.arvalid), 1);
        chk("araddr_stable", axi.araddr, prev_araddr);
      end
      if (ar_fire) chk("arvalid_drop", 32'(axi.arvalid), 0);
      if (axi.bready) chk("bready_before_aw_w_done", 32'(axi.awvalid | axi.wvalid), 0);

      if (b_fire) begin axi.bvalid = 0; b_fire = 0; end
      if (r_fire) begin axi.rvalid = 0; r_fire = 0; end
      if (b_pend) begin
        if (b_wait >= cfg_b_delay) begin
          axi.bvalid = 1; axi.bresp = cfg_bresp; b_pend = 0;
        end else b_wait++;
      end
      if (axi.bvalid && axi.bready) b_fire = 1;
      if (r_pend) begin
        if (r_wait >= cfg_r_delay) begin
          s_idx = (cap_araddr - BASE) >> 2;
          axi.rvalid = 1; axi.rdata = slv_mem[s_idx]; axi.rresp = cfg_rresp; r_pend = 0;
        end else r_wait++;
      end
      if (axi.rvalid && axi.rready) r_fire = 1;

      if (axi.awvalid) begin
        axi.awready = (aw_wait >= cfg_aw_delay);
        if (!axi.awready) aw_wait++;
      end else axi.awready = 0;
      aw_fire = axi.awvalid && axi.awready;
      aw_pend = axi.awvalid && !axi.awready;
      prev_awaddr = axi.awaddr;
      if (aw_fire) begin aw_wait = 0; cap_awaddr = axi.awaddr; got_aw = 1; aw_caps++; end

      if (axi.wvalid) begin
        axi.wready = (w_wait >= cfg_w_delay);
        if (!axi.wready) w_wait++;
      end else axi.wready = 0;
      w_fire = axi.wvalid && axi.wready;
      w_pend = axi.wvalid && !axi.wready;
      prev_wdata = axi.wdata;
      if (w_fire) begin
        w_wait = 0; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; got_w = 1; w_caps++;
      end

      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0;
        s_idx = (cap_awaddr - BASE) >> 2;
        if (cfg_bresp == 2'b00) begin
          for (int b = 0; b < 4; b++)
            if (cap_wstrb[b]) slv_mem[s_idx][8*b +: 8] = cap_wdata[8*b +: 8];
        end
        b_pend = 1; b_wait = 0;
      end

      if (axi.arvalid) begin
        axi.arready = (ar_wait >= cfg_ar_delay);
        if (!axi.arready) ar_wait++;
      end else axi.arready = 0;
      ar_fire = axi.arvalid && axi.arready;
      ar_pend = axi.arvalid && !axi.arready;
      prev_araddr = axi.araddr;
      if (ar_fire) begin
        ar_wait = 0; cap_araddr = axi.araddr; ar_caps++; r_pend = 1; r_wait = 0;
      end
    end
  end

  // One command through the DUT, checked against the reference model. Starts and ends just after a rising edge.
  task automatic run_cmd(input bit wr, input int unsigned idx, input logic [15:0] d, input int hold);
    logic [15:0] e_rd;
    logic        e_err;
    bit          in_rng;
    int          n, aw0, w0, ar0, v0;
    in_rng = (idx < NSYN);
    if (!in_rng) begin
      e_err = 1; e_rd = 0;
    end else if (wr) begin
      e_err = (cfg_bresp != 2'b00); e_rd = 0;
      if (!e_err) ref_w[idx] = d;
    end else begin
      e_err = (cfg_rresp != 2'b00); e_rd = ref_w[idx];
    end
    aw0 = aw_caps; w0 = w_caps; ar0 = ar_caps; v0 = valid_cycles;

    i_cmd_valid = 1; i_cmd_write = wr; i_cmd_index = 16'(idx); i_cmd_wdata = d;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", 32'(o_cmd_ready), 1);
    @(posedge clk); #1;
    i_cmd_valid = 0;
    chk("cmd_ready_busy", 32'(o_cmd_ready), 0);
    if (!in_rng) chk("oor_rsp_next_cycle", 32'(o_rsp_valid), 1);

    n = 0;
    while (o_rsp_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("rsp_valid_timeout", 32'(o_rsp_valid), 1);
    chk("rsp_rdata", 32'(o_rsp_rdata), 32'(e_rd));
    chk("rsp_error", 32'(o_rsp_error), 32'(e_err));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(o_rsp_valid), 1);
      chk("hold_rsp_rdata", 32'(o_rsp_rdata), 32'(e_rd));
      chk("hold_rsp_error", 32'(o_rsp_error), 32'(e_err));
      chk("hold_cmd_ready", 32'(o_cmd_ready), 0);
    end

    i_rsp_ready = 1;
    @(posedge clk); #1;
    i_rsp_ready = 0;
    chk("rsp_valid_cleared", 32'(o_rsp_valid), 0);
    chk("cmd_ready_returns", 32'(o_cmd_ready), 1);

    if (!in_rng) begin
      chk("oor_no_axi_valid", 32'(valid_cycles - v0), 0);
    end else if (wr) begin
      chk("aw_handshakes", 32'(aw_caps - aw0), 1);
      chk("w_handshakes", 32'(w_caps - w0), 1);
      chk("awaddr", cap_awaddr, BASE + 32'(idx) * 4);
      chk("wdata", cap_wdata, {16'h0, d});
      chk("wstrb", 32'(cap_wstrb), 32'h3);
    end else begin
      chk("ar_handshakes", 32'(ar_caps - ar0), 1);
      chk("araddr", cap_araddr, BASE + 32'(idx) * 4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    n_tests = 0; n_fail = 0;
    rst = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_index = 0; i_cmd_wdata = 0; i_rsp_ready = 0;
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_b_delay = 0; cfg_ar_delay = 0; cfg_r_delay = 0;
    cfg_bresp = 0; cfg_rresp = 0;
    for (int i = 0; i < NSYN; i++) begin
      v = $urandom;
      slv_mem[i] = v;
      ref_w[i] = v[15:0];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(o_cmd_ready), 0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(o_rsp_rdata), 0);
    chk("rst_rsp_error", 32'(o_rsp_error), 0);
    chk("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", 32'(axi.wstrb), 0);
    rst = 0;
    #1;
    chk("cmd_ready_after_rst", 32'(o_cmd_ready), 1);
    @(posedge clk); #1;

    run_cmd(1, 5, 16'hABCD, 0);
    chk("awaddr_idx5", cap_awaddr, 32'h4000_0014);
    chk("wdata_idx5", cap_wdata, 32'h0000_ABCD);

    cfg_aw_delay = 0; cfg_w_delay = 4;
    run_cmd(1, 7, 16'h1357, 0);
    cfg_w_delay = 0;

    slv_mem[3] = 32'hFFFF_1234; ref_w[3] = 16'h1234;
    run_cmd(0, 3, 16'h0, 0);
    cfg_rresp = 2'b10;
    run_cmd(0, 3, 16'h0, 0);
    cfg_rresp = 2'b00;
    cfg_bresp = 2'b11;
    run_cmd(1, 9, 16'hDEAD, 0);
    cfg_bresp = 2'b00;
    run_cmd(0, 9, 16'h0, 0);

    run_cmd(1, 220, 16'h1111, 0);
    run_cmd(0, 220, 16'h0, 0);
    run_cmd(0, 16'hFFFF, 16'h0, 0);
    run_cmd(1, 219, 16'h2222, 0);
    run_cmd(0, 219, 16'h0, 0);

    run_cmd(1, 100, 16'h0F0F, 10);
    run_cmd(0, 100, 16'h0, 0);

    cfg_aw_delay = 50; cfg_w_delay = 50;
    i_cmd_valid = 1; i_cmd_write = 1; i_cmd_index = 16'd10; i_cmd_wdata = 16'h5A5A;
    @(posedge clk); #1;
    i_cmd_valid = 0;
    chk("pre_rst_awvalid", 32'(axi.awvalid), 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("async_rst_awvalid", 32'(axi.awvalid), 0);
    chk("async_rst_wvalid", 32'(axi.wvalid), 0);
    chk("async_rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("async_rst_cmd_ready", 32'(o_cmd_ready), 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post_rst_cmd_ready", 32'(o_cmd_ready), 1);
    chk("post_rst_rsp_valid", 32'(o_rsp_valid), 0);
    cfg_aw_delay = 0; cfg_w_delay = 0;
    @(posedge clk); #1;
    run_cmd(0, 10, 16'h0, 0);
    run_cmd(1, 10, 16'h5A5A, 0);
    run_cmd(0, 10, 16'h0, 0);

    for (int k = 0; k < 60; k++) begin
      cfg_aw_delay = $urandom_range(0, 3);
      cfg_w_delay  = $urandom_range(0, 3);
      cfg_b_delay  = $urandom_range(0, 3);
      cfg_ar_delay = $urandom_range(0, 3);
      cfg_r_delay  = $urandom_range(0, 3);
      cfg_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cfg_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 239), 16'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
